// File: rtl/serial_to_parallel_reg.sv
// rtl/serial_to_parallel_reg.sv - LSB-first bit-serial to parallel deserializer with single-entry valid/ready output buffer.
// Optional even-parity bit after each word: define S2P_PARITY_EN (adds PARITY state and par_err output).
module serial_to_parallel_reg #(
  parameter int N = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         start,
  input  logic         D,
  input  logic         clr_ovr,
  output logic [N-1:0] Q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         busy,
  output logic         overrun
`ifdef S2P_PARITY_EN
  ,
  output logic         par_err
`endif
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [N-1:0]   sr, sr_nxt;
  logic [N-1:0]   word;
  logic           complete;
  logic           buf_free;
`ifdef S2P_PARITY_EN
  logic           perr;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    complete  = 1'b0;
    word      = sr;
`ifdef S2P_PARITY_EN
    perr      = 1'b0;
`endif
    if (en) begin
      // start wins over everything, including a completion on the same bit
      if (start) begin
        state_nxt = SHIFT;
        cnt_nxt   = CW'(1);
        sr_nxt    = {D, sr[N-1:1]};
      end else begin
        case (state)
          SHIFT: begin
            sr_nxt = {D, sr[N-1:1]};
            if (cnt == CW'(N-1)) begin
              cnt_nxt = '0;
`ifdef S2P_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = IDLE;
              complete  = 1'b1;
              word      = {D, sr[N-1:1]};
`endif
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
`ifdef S2P_PARITY_EN
          PARITY: begin
            state_nxt = IDLE;
            complete  = 1'b1;
            word      = sr;
            perr      = (^sr) ^ D;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign buf_free = !q_valid || q_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Output buffer: refill may coincide with a drain; a full, undrained buffer drops the word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
`ifdef S2P_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      if (complete && buf_free) begin
        Q       <= word;
        q_valid <= 1'b1;
`ifdef S2P_PARITY_EN
        par_err <= perr;
`endif
      end else if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end

      if (complete && !buf_free) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_reg.sv
// tb/tb_serial_to_parallel_reg.sv - directed self-checking bench for serial_to_parallel_reg at N=8.
// Parity-bit vectors are used when S2P_PARITY_EN is defined, data-only vectors otherwise.
module tb_serial_to_parallel_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic       start;
  logic       D;
  logic       clr_ovr;
  logic [7:0] Q;
  logic       q_valid;
  logic       q_ready;
  logic       busy;
  logic       overrun;
`ifdef S2P_PARITY_EN
  logic       par_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  serial_to_parallel_reg #(.N(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .start   (start),
    .D       (D),
    .clr_ovr (clr_ovr),
    .Q       (Q),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .busy    (busy),
    .overrun (overrun)
`ifdef S2P_PARITY_EN
    ,
    .par_err (par_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic d, input logic st);
    en    = 1'b1;
    start = st;
    D     = d;
    tick();
    en    = 1'b0;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic use_start);
    for (int i = 0; i < 8; i++) send_bit(w[i], use_start && (i == 0));
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b0; en = 1'b0; start = 1'b0; D = 1'b0; clr_ovr = 1'b0; q_ready = 1'b0;
    tick(); tick();
    chk("rst_q", 32'(Q), 32'h00);
    chk("rst_valid", 32'(q_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
`ifdef S2P_PARITY_EN
    chk("rst_perr", 32'(par_err), 32'd0);
`endif
    rst = 1'b1;
    q_ready = 1'b1;
    tick();

`ifndef S2P_PARITY_EN
    // 0xA5, en every cycle
    send_word(8'hA5, 1'b1);
    chk("a5_q", 32'(Q), 32'hA5);
    chk("a5_valid", 32'(q_valid), 32'd1);
    chk("a5_busy", 32'(busy), 32'd0);
    tick();
    chk("a5_drained", 32'(q_valid), 32'd0);

    // 0x3C with en toggling
    w = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        tick();
        chk("3c_busy_gap", 32'(busy), 32'd1);
      end
      send_bit(w[i], i == 0);
      if (i < 7) chk("3c_busy_bit", 32'(busy), 32'd1);
    end
    chk("3c_q", 32'(Q), 32'h3C);
    chk("3c_valid", 32'(q_valid), 32'd1);
    chk("3c_busy_end", 32'(busy), 32'd0);
    tick();
    chk("3c_drained", 32'(q_valid), 32'd0);

    // overrun with a stalled consumer
    q_ready = 1'b0;
    send_word(8'h11, 1'b1);
    chk("ovr_q1", 32'(Q), 32'h11);
    chk("ovr_valid1", 32'(q_valid), 32'd1);
    send_word(8'h22, 1'b1);
    chk("ovr_q_held", 32'(Q), 32'h11);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_valid2", 32'(q_valid), 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    q_ready = 1'b1;
    tick();
    chk("ovr_drain_valid", 32'(q_valid), 32'd0);
    chk("ovr_drain_q", 32'(Q), 32'h11);

    // simultaneous drain and refill
    q_ready = 1'b0;
    send_word(8'h11, 1'b1);
    w = 8'h22;
    for (int i = 0; i < 7; i++) send_bit(w[i], i == 0);
    q_ready = 1'b1;
    send_bit(w[7], 1'b0);
    chk("refill_q", 32'(Q), 32'h22);
    chk("refill_valid", 32'(q_valid), 32'd1);
    chk("refill_ovr", 32'(overrun), 32'd0);
    tick();
    chk("refill_drained", 32'(q_valid), 32'd0);

    // abort by re-asserted start
    w = 8'hFF;
    for (int i = 0; i < 4; i++) send_bit(w[i], i == 0);
    chk("abort_no_word", 32'(q_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    send_word(8'hC3, 1'b1);
    chk("abort_q", 32'(Q), 32'hC3);
    chk("abort_valid", 32'(q_valid), 32'd1);
    chk("abort_ovr", 32'(overrun), 32'd0);
    tick();
    chk("abort_drained", 32'(q_valid), 32'd0);

    // overrun set wins over clr_ovr
    q_ready = 1'b0;
    send_word(8'h01, 1'b1);
    clr_ovr = 1'b1;
    send_word(8'h02, 1'b1);
    clr_ovr = 1'b0;
    chk("ovr_prio", 32'(overrun), 32'd1);
    chk("ovr_prio_q", 32'(Q), 32'h01);
    clr_ovr = 1'b1;
    q_ready = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_prio_clr", 32'(overrun), 32'd0);
    chk("ovr_prio_drain", 32'(q_valid), 32'd0);

    // back-to-back frames, no idle gap
    send_word(8'h5A, 1'b1);
    chk("b2b_q1", 32'(Q), 32'h5A);
    chk("b2b_valid1", 32'(q_valid), 32'd1);
    send_word(8'h96, 1'b1);
    chk("b2b_q2", 32'(Q), 32'h96);
    chk("b2b_valid2", 32'(q_valid), 32'd1);

    // asynchronous reset mid-frame
    w = 8'h0F;
    for (int i = 0; i < 3; i++) send_bit(w[i], i == 0);
    rst = 1'b0;
    #1;
    chk("mrst_q", 32'(Q), 32'h00);
    chk("mrst_valid", 32'(q_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ovr", 32'(overrun), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    send_word(8'hFF, 1'b0);
    chk("nostart_valid", 32'(q_valid), 32'd0);
    chk("nostart_busy", 32'(busy), 32'd0);
    chk("nostart_q", 32'(Q), 32'h00);
`else
    // 0xA5 with correct even parity
    send_word(8'hA5, 1'b1);
    chk("p0_wait_valid", 32'(q_valid), 32'd0);
    chk("p0_wait_busy", 32'(busy), 32'd1);
    send_bit(1'b0, 1'b0);
    chk("p0_q", 32'(Q), 32'hA5);
    chk("p0_valid", 32'(q_valid), 32'd1);
    chk("p0_perr", 32'(par_err), 32'd0);
    chk("p0_busy", 32'(busy), 32'd0);
    tick();
    chk("p0_drained", 32'(q_valid), 32'd0);

    // 0xA5 with wrong parity bit
    send_word(8'hA5, 1'b1);
    chk("p1_wait_valid", 32'(q_valid), 32'd0);
    send_bit(1'b1, 1'b0);
    chk("p1_q", 32'(Q), 32'hA5);
    chk("p1_valid", 32'(q_valid), 32'd1);
    chk("p1_perr", 32'(par_err), 32'd1);
    tick();

    // 0x07 (odd weight) with parity 1 is clean; drop check moves to the parity bit
    q_ready = 1'b0;
    send_word(8'h07, 1'b1);
    send_bit(1'b1, 1'b0);
    chk("p2_q", 32'(Q), 32'h07);
    chk("p2_perr", 32'(par_err), 32'd0);
    send_word(8'h33, 1'b1);
    chk("p2_no_ovr_yet", 32'(overrun), 32'd0);
    send_bit(1'b0, 1'b0);
    chk("p2_ovr", 32'(overrun), 32'd1);
    chk("p2_q_held", 32'(Q), 32'h07);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_reg.md
Name: serial_to_parallel_reg

Overview:
- Bit-serial to parallel deserializer. It is the receive-side counterpart of the parallel-load shift register used in the DA filter datapath.
- Collects N bits that arrive LSB first, one bit per enabled cycle. Bit 0 is marked by a start strobe.
- Presents each completed word on a single-entry output buffer with a valid/ready handshake, so bit-serial DA results can be handed to word-wide logic downstream.

Parameters:
- N, 20, word width in bits. Legal range is N >= 2.
- CW, $clog2(N), bit-counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low. All state clears while rst = 0.
- en  input  1  serial bit strobe. D is sampled only on cycles where en = 1.
- start  input  1  frame start. Qualified by en. Marks the current D as bit 0.
- D  input  1  serial data bit, LSB first.
- clr_ovr  input  1  synchronous clear of the overrun flag.
- Q  output  N  parallel word held in the output buffer.
- q_valid  output  1  output buffer holds an unconsumed word.
- q_ready  input  1  consumer accepts Q when q_valid = 1 and q_ready = 1.
- busy  output  1  a frame is being collected (state SHIFT or PARITY).
- overrun  output  1  sticky. A completed word was dropped because the buffer was full.

Behaviour:
- Reset values (asynchronous on rst low): state = IDLE, bit counter = 0, shift register = 0, Q = 0, q_valid = 0, busy = 0, overrun = 0.
- Shift register: on each accepted bit, sr <= {D, sr[N-1:1]}. After N accepted bits, sr[0] is the first bit received.
- States:
  - IDLE: en = 1 with start = 1 accepts bit 0, sets cnt = 1, goes to SHIFT. en = 1 with start = 0 is ignored; no shift occurs.
  - SHIFT: en = 1 accepts a bit and increments cnt. When the bit accepted at cnt == N-1 is the Nth bit, the word completes and the FSM returns to IDLE (or goes to PARITY, see Optional Feature). en = 0 holds all state.
- start with en while in SHIFT or PARITY aborts the current frame with no output and no flag. That bit becomes bit 0 and cnt = 1. start takes priority over completion when both apply in the same cycle.
- Word completion, cycle C: the completed word {D, sr[N-1:1]} loads Q at the clock edge ending C. q_valid = 1 from cycle C+1, so latency is one clock after the final bit.
- Buffer free condition: the load happens if q_valid = 0, or if q_valid & q_ready in cycle C (simultaneous drain and refill). In that case q_valid stays 1 and Q updates.
- Buffer full: if q_valid = 1 and q_ready = 0 in cycle C, the word is dropped. Q is unchanged and overrun <= 1.
- Handshake: q_valid & q_ready with no load in the same cycle clears q_valid the next cycle. Q holds its last value after it is consumed. Q must not change while q_valid = 1 unless it is being drained that same cycle.
- overrun: set has priority over clr_ovr in the same cycle. Otherwise clr_ovr = 1 clears it next cycle.
- busy = 1 in SHIFT or PARITY, registered from state.
- Reset asserted mid-frame discards the partial word immediately. After release, bits are ignored until the next start.
- Back-to-back frames: start may be asserted on the cycle right after completion, with no idle gap required.

Optional Feature:
- Macro: S2P_PARITY_EN.
- Defined:
  - After the Nth data bit the FSM enters PARITY instead of IDLE. The next en bit is an even-parity bit.
  - Completion, the load, and the overrun check move to that bit.
  - Adds output par_err (1 bit), registered with Q: par_err = ^data ^ parity_bit. It is valid while q_valid = 1 and reset value is 0.
  - Latency is one clock after the parity bit.
- Undefined: no PARITY state and no par_err port. Behaviour is as described above.

Test Plan:
- N=8, q_ready=1. Send 0xA5 LSB first (bits 1,0,1,0,0,1,0,1), start on bit 0, en every cycle -> Q=0xA5 and q_valid=1 exactly one cycle after bit 7, q_valid=0 the next cycle.
- N=8, en toggling 1/0 during the frame carrying 0x3C -> Q=0x3C. Bits sampled only on en cycles; busy=1 from bit 0 through bit 7.
- N=8, q_ready=0, send 0x11 then 0x22 -> Q stays 0x11 and overrun=1. Pulse clr_ovr -> overrun=0. Raise q_ready -> q_valid drops; Q holds 0x11.
- N=8, q_valid=1 holding 0x11, q_ready=1 on the completion cycle of 0x22 -> Q=0x22, q_valid stays 1, overrun stays 0.
- N=8, start re-asserted after 4 bits of a frame, then a full 0xC3 -> only 0xC3 is output, overrun=0. Also assert rst low mid-frame -> all outputs 0, and a following frame without start yields no word.
- S2P_PARITY_EN, N=8: 0xA5 with parity 0 -> par_err=0. 0xA5 with parity 1 -> par_err=1. q_valid rises one cycle after the parity bit.
